exc_vector_seq: RTL and testbench
=================================

Name: exc_vector_seq

Overview:
- Exception sequencer for the multicycle CPU.
- Detects invalid opcode, ALU overflow and divide-by-zero, and saves the faulting PC to EPC.
- Drives the memory-address mux selector to the fixed vector bytes 253/254/255, waits for memory read data, then loads PC with the zero-extended handler byte.
- Sits upstream of the memory-address mux, in parallel with the main control unit; while exc_active is high, the top level gives this block ownership of the selector, the PC write and the EPC write.

Parameters:
- MEM_LAT, 1: memory read latency in cycles, from address valid to mem_data_in valid; legal range 1..7.
- PC_INC, 4: amount by which pc_in has already been incremented past the faulting instruction.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- bad_opcode  in  1  decode found an unknown opcode; single-cycle pulse
- overflow  in  1  ALU signed overflow on the current instruction; single-cycle pulse
- div_zero  in  1  divider detected divisor == 0; single-cycle pulse
- pc_in  in  32  current PC register value, already incremented
- mem_data_in  in  32  memory read data
- mux_sel  out  3  selector to the memory-address mux
- mem_wr  out  1  memory write enable; always 0 from this block
- exc_active  out  1  high while the block owns the datapath controls
- epc_out  out  32  value to write into EPC
- epc_wr  out  1  EPC write strobe
- pc_out  out  32  handler address for PC
- pc_wr  out  1  PC write strobe

Behaviour:
- Reset is asynchronous on reset_n low. All outputs go to 0 and the state goes to IDLE.
- States and transitions:
  - IDLE: waits for a trigger.
  - SAVE: 1 cycle. epc_wr=1, epc_out = pc_in - PC_INC (32-bit wrap, no saturation). The cause is latched on entry.
  - ADDR: 1 cycle. mux_sel is driven to the cause code; the wait counter is loaded with MEM_LAT-1.
  - WAIT: counts down to 0. mux_sel is held. Exits when the count is 0; with MEM_LAT=1 this state is left after 1 cycle.
  - LOAD: 1 cycle. pc_out = {24'b0, mem_data_in[7:0]}, pc_wr=1.
  - Returns to IDLE.
- Trigger: any trigger input high while in IDLE moves the block to SAVE on the next edge. Triggers seen in any other state are ignored and are not queued.
- Priority when triggers are simultaneous: bad_opcode > overflow > div_zero.
- Cause codes on mux_sel: bad_opcode = 3'b100 (address 253), overflow = 3'b101 (254), div_zero = 3'b110 (255).
- exc_active is registered. It is 1 in SAVE, ADDR, WAIT and LOAD, and 0 in IDLE.
- mux_sel outside ADDR and WAIT is 3'b000.
- epc_wr and pc_wr are single-cycle pulses. epc_out and pc_out hold their last value between writes.
- Total latency from trigger sample to the pc_wr pulse: MEM_LAT + 3 cycles.
- mem_wr is tied to 0.
- Reset asserted mid-sequence aborts immediately; no partial PC write follows.
- X on the trigger inputs while in IDLE must not corrupt the state. Each trigger is qualified with === 1'b1 in assertions only; the RTL treats X as 0 via a default branch.

Optional Feature:
- Macro: EXC_CAUSE_REG_EN
- Defined:
  - Adds output cause_out[1:0] (01 = opcode, 10 = overflow, 11 = div0), updated in SAVE, holds until the next exception, resets to 00.
  - Adds output exc_count[7:0], incremented on each pc_wr and wrapping 255 -> 0.
- Undefined: neither port exists, and the behaviour is otherwise identical.

Decomposition:
- Package exc_pkg holds:
  - the state encoding: IDLE, SAVE, ADDR, WAIT, LOAD;
  - selector constants SEL_PC=3'b000, SEL_VEC_OPC=3'b100, SEL_VEC_OVF=3'b101, SEL_VEC_DIV=3'b110;
  - cause code constants.
- One sub-module, exc_wait_cnt: a 3-bit loadable down-counter with a zero flag, implementing the WAIT stage.

Test Plan:
- MEM_LAT=1. Pulse overflow with pc_in=0x0000_0108 and memory[254]=0x3C. Expect:
  - epc_wr with epc_out=0x104;
  - mux_sel=101 for 2 cycles;
  - pc_wr with pc_out=0x3C, 4 cycles after the trigger;
  - exc_active falls the cycle after pc_wr.
- Pulse bad_opcode and div_zero in the same cycle. Expect mux_sel=100 only, and div_zero is never serviced.
- MEM_LAT=3. Pulse div_zero. Expect mux_sel=110 for 4 cycles, pc_out=mem[255] zero-extended, and pc_wr 6 cycles after the trigger.
- Pulse overflow again while in WAIT. Expect no restart, exactly one pc_wr, and a return to IDLE.
- Assert reset_n low during WAIT. Expect all outputs 0 asynchronously and no pc_wr after release.
- With EXC_CAUSE_REG_EN defined:
  - three back-to-back exceptions give exc_count=3, and cause_out tracks the last cause;
  - 256 exceptions wrap exc_count to 0.

Source files
------------

// File: rtl/exc_vector_seq_pkg.sv
// Shared types and constants for the exception vector sequencer.
// Used by exc_vector_seq (top) and exc_wait_cnt.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SAVE = 3'd1,
    ADDR = 3'd2,
    WAIT = 3'd3,
    LOAD = 3'd4
  } state_t;

  // Memory-address mux selector values; the vector codes select bytes 253/254/255.
  localparam logic [2:0] SEL_PC      = 3'b000;
  localparam logic [2:0] SEL_VEC_OPC = 3'b100;
  localparam logic [2:0] SEL_VEC_OVF = 3'b101;
  localparam logic [2:0] SEL_VEC_DIV = 3'b110;

  // Latched exception cause; CAUSE_NONE means no trigger present.
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_OPC  = 2'b01;
  localparam logic [1:0] CAUSE_OVF  = 2'b10;
  localparam logic [1:0] CAUSE_DIV  = 2'b11;

  function automatic logic [2:0] cause_sel(input logic [1:0] cause);
    case (cause)
      CAUSE_OPC: cause_sel = SEL_VEC_OPC;
      CAUSE_OVF: cause_sel = SEL_VEC_OVF;
      CAUSE_DIV: cause_sel = SEL_VEC_DIV;
      default:   cause_sel = SEL_PC;
    endcase
  endfunction

endpackage

// File: rtl/exc_vector_seq_wait_cnt.sv
// 3-bit loadable down-counter with zero flag; times the memory read wait.
// Load has priority; the counter parks at zero until the next load.
module exc_wait_cnt
  import exc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       zero
);

  logic [2:0] cnt;

  // Load on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign zero = (cnt == 3'd0);

endmodule

// File: rtl/exc_vector_seq.sv
// Exception sequencer: saves the faulting PC to EPC, fetches the handler byte
// from the fixed vector address and loads it into PC.
// Optional feature macro: EXC_CAUSE_REG_EN adds cause_out and exc_count.
//
// state | meaning
// IDLE  | waiting for a trigger
// SAVE  | EPC write of pc_in - PC_INC, cause latched
// ADDR  | vector selector driven, wait counter loaded with MEM_LAT-1
// WAIT  | selector held until the read data is valid
// LOAD  | PC write with the zero-extended handler byte
module exc_vector_seq
  import exc_pkg::*;
#(
  parameter int MEM_LAT = 1,  // legal 1..7
  parameter int PC_INC  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bad_opcode,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  mux_sel,
  output logic        mem_wr,
  output logic        exc_active,
  output logic [31:0] epc_out,
  output logic        epc_wr,
  output logic [31:0] pc_out,
  output logic        pc_wr
`ifdef EXC_CAUSE_REG_EN
  ,
  output logic [1:0]  cause_out,
  output logic [7:0]  exc_count
`endif
);

  localparam logic [2:0]  WAIT_LOAD = 3'(MEM_LAT - 1);
  localparam logic [31:0] PC_DEC    = 32'(PC_INC);

  state_t     state;
  logic [1:0] cause;
  logic [1:0] trig_cause;
  logic       cnt_zero;
  logic       unused_mem_hi;

  assign mem_wr        = 1'b0;
  assign unused_mem_hi = ^mem_data_in[31:8];

  // Priority-encode the triggers; X or no trigger falls into the default branch.
  always_comb begin
    trig_cause = CAUSE_NONE;
    casez ({bad_opcode, overflow, div_zero})
      3'b1??:  trig_cause = CAUSE_OPC;
      3'b01?:  trig_cause = CAUSE_OVF;
      3'b001:  trig_cause = CAUSE_DIV;
      default: trig_cause = CAUSE_NONE;
    endcase
  end

  exc_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state == ADDR),
    .load_val (WAIT_LOAD),
    .zero     (cnt_zero)
  );

  // Sequencer FSM with all datapath controls registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cause      <= CAUSE_NONE;
      mux_sel    <= SEL_PC;
      exc_active <= 1'b0;
      epc_out    <= 32'd0;
      epc_wr     <= 1'b0;
      pc_out     <= 32'd0;
      pc_wr      <= 1'b0;
    end else begin
      epc_wr <= 1'b0;
      pc_wr  <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_cause != CAUSE_NONE) begin
            state      <= SAVE;
            cause      <= trig_cause;
            exc_active <= 1'b1;
            epc_wr     <= 1'b1;
            epc_out    <= pc_in - PC_DEC;
          end
        end
        SAVE: begin
          state   <= ADDR;
          mux_sel <= cause_sel(cause);
        end
        ADDR: begin
          state <= WAIT;
        end
        WAIT: begin
          if (cnt_zero) begin
            state   <= LOAD;
            mux_sel <= SEL_PC;
            pc_out  <= {24'd0, mem_data_in[7:0]};
            pc_wr   <= 1'b1;
          end
        end
        LOAD: begin
          state      <= IDLE;
          exc_active <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          mux_sel    <= SEL_PC;
          exc_active <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_CAUSE_REG_EN
  assign cause_out = cause;

  // Count completed handler loads; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exc_count <= 8'd0;
    end else if (pc_wr) begin
      exc_count <= exc_count + 8'd1;
    end
  end
`endif

  // A definite bad_opcode in IDLE must always start the save step.
  a_opc_starts: assert property (@(posedge clk) disable iff (!reset_n)
    (state == IDLE && bad_opcode === 1'b1) |=> (state == SAVE));

  // The PC write strobe is never longer than one cycle.
  a_pc_wr_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    pc_wr |=> !pc_wr);

endmodule

// File: tb/tb_exc_vector_seq.sv
// Directed bench for exc_vector_seq with MEM_LAT=1 (u1) and MEM_LAT=3 (u3).
module tb_exc_vector_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bad_opcode = 1'b0, overflow = 1'b0, div_zero = 1'b0;
  logic [31:0] pc_in = 32'd0;

  logic [31:0] md1, md3, epc1, epc3, pco1, pco3;
  logic [2:0]  ms1, ms3;
  logic        mw1, mw3, act1, act3, epcwr1, epcwr3, pcwr1, pcwr3;
`ifdef EXC_CAUSE_REG_EN
  logic [1:0]  co1, co3;
  logic [7:0]  cnt1, cnt3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exc_vector_seq #(.MEM_LAT(1), .PC_INC(4)) u1 (
    .clk(clk), .reset_n(reset_n), .bad_opcode(bad_opcode), .overflow(overflow),
    .div_zero(div_zero), .pc_in(pc_in), .mem_data_in(md1), .mux_sel(ms1),
    .mem_wr(mw1), .exc_active(act1), .epc_out(epc1), .epc_wr(epcwr1),
    .pc_out(pco1), .pc_wr(pcwr1)
`ifdef EXC_CAUSE_REG_EN
    , .cause_out(co1), .exc_count(cnt1)
`endif
  );

  exc_vector_seq #(.MEM_LAT(3), .PC_INC(4)) u3 (
    .clk(clk), .reset_n(reset_n), .bad_opcode(bad_opcode), .overflow(overflow),
    .div_zero(div_zero), .pc_in(pc_in), .mem_data_in(md3), .mux_sel(ms3),
    .mem_wr(mw3), .exc_active(act3), .epc_out(epc3), .epc_wr(epcwr3),
    .pc_out(pco3), .pc_wr(pcwr3)
`ifdef EXC_CAUSE_REG_EN
    , .cause_out(co3), .exc_count(cnt3)
`endif
  );

  // Memory model: vector bytes carry non-zero upper bits to expose missing zero-extension.
  function automatic logic [31:0] mem_rd(input logic [2:0] sel);
    case (sel)
      3'b100:  mem_rd = 32'hFFFF_FFA5;
      3'b101:  mem_rd = 32'h1234_563C;
      3'b110:  mem_rd = 32'hCAFE_0077;
      default: mem_rd = 32'hBAD0_0011;
    endcase
  endfunction

  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    md1   <= mem_rd(ms1);
    p3[0] <= mem_rd(ms3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign md3 = p3[2];

  task automatic test_reset;
    #3;
    checks++; if ({ms1, mw1, act1, epcwr1, pcwr1} !== 7'd0 || epc1 !== 32'd0 || pco1 !== 32'd0) begin
      errors++; $display("FAIL reset_u1: got ms=%b act=%b epc=%h pc=%h expected all zero", ms1, act1, epc1, pco1);
    end
    checks++; if ({ms3, mw3, act3, epcwr3, pcwr3} !== 7'd0 || epc3 !== 32'd0 || pco3 !== 32'd0) begin
      errors++; $display("FAIL reset_u3: got ms=%b act=%b epc=%h pc=%h expected all zero", ms3, act3, epc3, pco3);
    end
`ifdef EXC_CAUSE_REG_EN
    checks++; if (co1 !== 2'b00 || cnt1 !== 8'd0) begin
      errors++; $display("FAIL reset_cause: got cause=%b count=%0d expected 00 0", co1, cnt1);
    end
`endif
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overflow;
    int npc;
    npc = 0;
    repeat (10) @(negedge clk);
    pc_in = 32'h0000_0108; overflow = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); overflow = 1'b0;
      checks++; if (ms1 !== ((k == 2 || k == 3) ? 3'b101 : 3'b000)) begin
        errors++; $display("FAIL ovf_mux_sel c%0d: got %b expected %b", k, ms1, (k == 2 || k == 3) ? 3'b101 : 3'b000);
      end
      checks++; if (pcwr1 !== (k == 4) || epcwr1 !== (k == 1)) begin
        errors++; $display("FAIL ovf_strobes c%0d: got pc_wr=%b epc_wr=%b expected %b %b", k, pcwr1, epcwr1, k == 4, k == 1);
      end
      checks++; if (act1 !== (k <= 4) || mw1 !== 1'b0) begin
        errors++; $display("FAIL ovf_active c%0d: got act=%b mem_wr=%b expected %b 0", k, act1, mw1, k <= 4);
      end
      if (k == 1) begin
        checks++; if (epc1 !== 32'h104) begin
          errors++; $display("FAIL ovf_epc: got %h expected 00000104", epc1);
        end
      end
      if (pcwr1 === 1'b1) npc++;
    end
    checks++; if (pco1 !== 32'h0000_003C || npc != 1) begin
      errors++; $display("FAIL ovf_pc_out: got %h writes=%0d expected 0000003c 1", pco1, npc);
    end
  endtask

  task automatic test_priority;
    int npc;
    npc = 0;
    repeat (10) @(negedge clk);
    pc_in = 32'h0000_0400; bad_opcode = 1'b1; div_zero = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk); bad_opcode = 1'b0; div_zero = 1'b0;
      checks++; if (ms1 !== ((k == 2 || k == 3) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL prio_mux_sel c%0d: got %b expected %b", k, ms1, (k == 2 || k == 3) ? 3'b100 : 3'b000);
      end
      if (k >= 5) begin
        checks++; if (act1 !== 1'b0) begin
          errors++; $display("FAIL prio_no_div c%0d: got act=%b expected 0", k, act1);
        end
      end
      if (pcwr1 === 1'b1) npc++;
    end
    checks++; if (npc != 1 || pco1 !== 32'h0000_00A5 || epc1 !== 32'h0000_03FC) begin
      errors++; $display("FAIL prio_result: got writes=%0d pc=%h epc=%h expected 1 000000a5 000003fc", npc, pco1, epc1);
    end
  endtask

  task automatic test_div_zero_lat3;
    repeat (10) @(negedge clk);
    pc_in = 32'h0000_0000; div_zero = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); div_zero = 1'b0;
      checks++; if (ms3 !== ((k >= 2 && k <= 5) ? 3'b110 : 3'b000)) begin
        errors++; $display("FAIL div3_mux_sel c%0d: got %b expected %b", k, ms3, (k >= 2 && k <= 5) ? 3'b110 : 3'b000);
      end
      checks++; if (pcwr3 !== (k == 6) || act3 !== (k <= 6)) begin
        errors++; $display("FAIL div3_timing c%0d: got pc_wr=%b act=%b expected %b %b", k, pcwr3, act3, k == 6, k <= 6);
      end
    end
    checks++; if (pco3 !== 32'h0000_0077 || epc3 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL div3_result: got pc=%h epc=%h expected 00000077 fffffffc", pco3, epc3);
    end
  endtask

  task automatic test_retrigger;
    int npc;
    npc = 0;
    repeat (10) @(negedge clk);
    pc_in = 32'h0000_2000; bad_opcode = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk); bad_opcode = 1'b0; overflow = 1'b0;
      checks++; if (ms3 !== ((k >= 2 && k <= 5) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL retrig_mux_sel c%0d: got %b expected %b", k, ms3, (k >= 2 && k <= 5) ? 3'b100 : 3'b000);
      end
      if (pcwr3 === 1'b1) npc++;
      if (k == 4) overflow = 1'b1;
    end
    checks++; if (npc != 1 || act3 !== 1'b0 || pco3 !== 32'h0000_00A5) begin
      errors++; $display("FAIL retrig_result: got writes=%0d act=%b pc=%h expected 1 0 000000a5", npc, act3, pco3);
    end
  endtask

  task automatic test_reset_mid;
    repeat (10) @(negedge clk);
    pc_in = 32'h0000_3000; div_zero = 1'b1;
    repeat (4) begin
      @(negedge clk); div_zero = 1'b0;
    end
    checks++; if (act3 !== 1'b1 || ms3 !== 3'b110) begin
      errors++; $display("FAIL rstmid_pre: got act=%b ms=%b expected 1 110", act3, ms3);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({ms3, mw3, act3, epcwr3, pcwr3} !== 7'd0 || epc3 !== 32'd0 || pco3 !== 32'd0) begin
      errors++; $display("FAIL rstmid_async: got ms=%b act=%b pc_wr=%b epc=%h pc=%h expected all zero", ms3, act3, pcwr3, epc3, pco3);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++; if (pcwr3 !== 1'b0 || act3 !== 1'b0 || pco3 !== 32'd0) begin
        errors++; $display("FAIL rstmid_after c%0d: got pc_wr=%b act=%b pc=%h expected 0 0 0", k, pcwr3, act3, pco3);
      end
    end
  endtask

`ifdef EXC_CAUSE_REG_EN
  task automatic test_back_to_back;
    logic [1:0] exp_c [0:2];
    exp_c[0] = 2'b01; exp_c[1] = 2'b11; exp_c[2] = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bad_opcode = (i == 0); div_zero = (i == 1); overflow = (i == 2);
      @(negedge clk); bad_opcode = 1'b0; div_zero = 1'b0; overflow = 1'b0;
      checks++; if (co1 !== exp_c[i]) begin
        errors++; $display("FAIL b2b_cause %0d: got %b expected %b", i, co1, exp_c[i]);
      end
      repeat (4) @(negedge clk);
    end
    checks++; if (cnt1 !== 8'd3 || co1 !== 2'b10) begin
      errors++; $display("FAIL b2b_count: got count=%0d cause=%b expected 3 10", cnt1, co1);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 252; i++) begin
      overflow = 1'b1;
      @(negedge clk); overflow = 1'b0;
      repeat (4) @(negedge clk);
    end
    checks++; if (cnt1 !== 8'd255) begin
      errors++; $display("FAIL wrap_255: got %0d expected 255", cnt1);
    end
    div_zero = 1'b1;
    @(negedge clk); div_zero = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (cnt1 !== 8'd0 || co1 !== 2'b11) begin
      errors++; $display("FAIL wrap_0: got count=%0d cause=%b expected 0 11", cnt1, co1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_overflow();
    test_priority();
    test_div_zero_lat3();
    test_retrigger();
    test_reset_mid();
`ifdef EXC_CAUSE_REG_EN
    test_back_to_back();
    test_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
